vga_tile_blitter: RTL and testbench

//  iomem bus initiator that fills a rectangle of the VGA tile map with one tile index.

---
 rtl/vga_tile_blitter.sv | 196 +++++++++++++++++++
 tb/tb_vga_tile_blitter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_blitter.sv
// iomem bus initiator that fills a clipped rectangle of the VGA tile map with one tile index.
// Optional ready timeout is enabled by defining VGA_BLIT_TIMEOUT_EN.
module vga_tile_blitter #(
  parameter logic [31:0] MAP_BASE = 32'h0020_0000,
  parameter int unsigned COLS     = 40,
  parameter int unsigned ROWS     = 30,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_x0,
  input  logic [4:0]  cmd_y0,
  input  logic [5:0]  cmd_w,
  input  logic [4:0]  cmd_h,
  input  logic [3:0]  cmd_tile,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata
);

  localparam int unsigned XW  = 6;
  localparam int unsigned YW  = 5;
  localparam int unsigned XSW = XW + 1;
  localparam int unsigned YSW = YW + 1;
  localparam int unsigned IW  = 11;
  localparam int unsigned TW  = 4;

  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, GAP, DONE} state_t;

  state_t          state_q, state_n;
  logic [XW-1:0]   x0_q, xe_q, x_q, x_n;
  logic [YW-1:0]   y0_q, ye_q, y_q, y_n;
  logic [TW-1:0]   tile_q;
  logic            empty_q;

  logic            accept;
  logic [XSW-1:0]  sum_x;
  logic [YSW-1:0]  sum_y;
  logic [XW-1:0]   xe_c;
  logic [YW-1:0]   ye_c;
  logic            empty_c;
  logic            last_col;
  logic            last_row;
  logic [IW-1:0]   idx_c;
  logic [31:0]     addr_c;
  logic            timeout_c;

  assign accept = cmd_valid && cmd_ready;

  // Clip the rectangle to the map at acceptance
  always_comb begin
    sum_x   = XSW'(cmd_x0) + XSW'(cmd_w);
    sum_y   = YSW'(cmd_y0) + YSW'(cmd_h);
    xe_c    = (sum_x > XSW'(COLS)) ? XW'(COLS) : sum_x[XW-1:0];
    ye_c    = (sum_y > YSW'(ROWS)) ? YW'(ROWS) : sum_y[YW-1:0];
    empty_c = (cmd_w == '0) || (cmd_h == '0) ||
              (cmd_x0 >= XW'(COLS)) || (cmd_y0 >= YW'(ROWS));
  end

  assign last_col = ((x_q + XW'(1)) == xe_q);
  assign last_row = ((y_q + YW'(1)) == ye_q);

  // Byte address of the cell the FSM is about to issue
  assign idx_c  = IW'(y_n) * IW'(COLS) + IW'(x_n);
  assign addr_c = MAP_BASE + 32'({idx_c, 2'b00});

`ifdef VGA_BLIT_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;

  assign timeout_c = (state_q == ISSUE) && !iomem_ready && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if ((state_q == ISSUE) && !iomem_ready && !timeout_c) begin
      cnt_q <= cnt_q + CW'(1);
    end else begin
      cnt_q <= '0;
    end
  end
`else
  logic unused_timeout;
  assign timeout_c      = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_n;
      x_q     <= x_n;
      y_q     <= y_n;
    end
  end

  always_comb begin
    state_n = state_q;
    x_n     = x_q;
    y_n     = y_q;
    case (state_q)
      IDLE: begin
        if (accept) state_n = SETUP;
      end
      SETUP: begin
        if (empty_q) begin
          state_n = DONE;
        end else begin
          state_n = ISSUE;
          x_n     = x0_q;
          y_n     = y0_q;
        end
      end
      ISSUE: begin
        if (iomem_valid && iomem_ready) state_n = GAP;
        else if (timeout_c)             state_n = DONE;
      end
      GAP: begin
        if (last_col) begin
          if (last_row) begin
            state_n = DONE;
          end else begin
            state_n = ISSUE;
            x_n     = x0_q;
            y_n     = y_q + YW'(1);
          end
        end else begin
          state_n = ISSUE;
          x_n     = x_q + XW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Command latch
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x0_q    <= '0;
      y0_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      tile_q  <= '0;
      empty_q <= 1'b0;
    end else if (accept) begin
      x0_q    <= cmd_x0;
      y0_q    <= cmd_y0;
      xe_q    <= xe_c;
      ye_q    <= ye_c;
      tile_q  <= cmd_tile;
      empty_q <= empty_c;
    end
  end

  // Registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      iomem_valid <= 1'b0;
      iomem_wstrb <= 4'b0000;
      iomem_addr  <= '0;
      iomem_wdata <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cmd_ready   <= 1'b1;
    end else begin
      iomem_valid <= (state_n == ISSUE);
      iomem_wstrb <= (state_n == ISSUE) ? 4'b1111 : 4'b0000;
      if (state_n == ISSUE) begin
        iomem_addr  <= addr_c;
        iomem_wdata <= 32'(tile_q);
      end
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      cmd_ready <= (state_n == IDLE);
    end
  end

  // Sticky timeout flag, cleared by the next accepted command
  always_ff @(posedge clk) begin
    if (!resetn)        err <= 1'b0;
    else if (accept)    err <= 1'b0;
    else if (timeout_c) err <= 1'b1;
  end

endmodule

// File: tb/tb_vga_tile_blitter.sv
// Directed bench for vga_tile_blitter: fills, clipping, empty commands, slow ready, reset abort.
// With VGA_BLIT_TIMEOUT_EN defined it also exercises the ready timeout (TIMEOUT=8).
module tb_vga_tile_blitter;

`ifdef VGA_BLIT_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_x0;
  logic [4:0]  cmd_y0;
  logic [5:0]  cmd_w;
  logic [4:0]  cmd_h;
  logic [3:0]  cmd_tile;
  logic        busy;
  logic        done;
  logic        err;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_addr[$];
  logic        ready_idle = 1'b0;

  always #5 clk = ~clk;

  vga_tile_blitter #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_x0      (cmd_x0),
    .cmd_y0      (cmd_y0),
    .cmd_w       (cmd_w),
    .cmd_h       (cmd_h),
    .cmd_tile    (cmd_tile),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one command and act as the iomem responder; ready rises d cycles after valid.
  // Cycle 1 is the first cycle after the accept edge. stop_cyc != 0 returns early.
  task automatic run_cmd(input logic [5:0] x0, input logic [4:0] y0, input logic [5:0] w,
                         input logic [4:0] h, input logic [3:0] tile, input int d,
                         input int exp_done, input int exp_nw, input int stop_cyc,
                         input bit spam);
    int cyc = 0;
    int k   = 0;
    int nw  = 0;
    bit gap_due = 1'b0;
    bit fin = 1'b0;
    @(negedge clk);
    check("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_tile = tile;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (spam) begin
        cmd_valid = 1'b1; cmd_x0 = 6'd9; cmd_y0 = 5'd9; cmd_w = 6'd1; cmd_h = 5'd1;
        cmd_tile = ~tile;
      end else begin
        cmd_valid = 1'b0;
      end
      if (cyc == 1) begin
        check("busy_after_accept", 32'(busy), 32'd1);
        check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        check("err_cleared", 32'(err), 32'd0);
      end
      if (gap_due) begin
        check("gap_valid_low", 32'(iomem_valid), 32'd0);
        gap_due = 1'b0;
      end
      if (iomem_valid) begin
        k++;
        check("addr", iomem_addr, (nw < exp_addr.size()) ? exp_addr[nw] : 32'hDEAD_BEEF);
        check("wdata", iomem_wdata, 32'(tile));
        check("wstrb", 32'(iomem_wstrb), 32'hF);
        if (k > d) begin
          iomem_ready = 1'b1; nw++; k = 0; gap_due = 1'b1;
        end else begin
          iomem_ready = 1'b0;
        end
      end else begin
        k = 0;
        iomem_ready = ready_idle;
      end
      if (done) begin
        check("done_cycle", 32'(cyc), 32'(exp_done));
        cmd_valid = 1'b0;
        fin = 1'b1;
      end
      if (stop_cyc != 0 && cyc == stop_cyc) return;
    end
    check("done_seen", 32'(fin), 32'd1);
    check("num_writes", 32'(nw), 32'(exp_nw));
    @(negedge clk);
    iomem_ready = 1'b0;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    check("valid_idle", 32'(iomem_valid), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; cmd_valid = 1'b0; cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0;
    cmd_tile = '0; iomem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(iomem_valid), 32'd0);
    check("rst_wstrb", 32'(iomem_wstrb), 32'd0);
    check("rst_addr", iomem_addr, 32'd0);
    check("rst_wdata", iomem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    // 2x2 fill at (3,1), spam commands while busy
    exp_addr.delete();
    exp_addr.push_back(32'h0020_00AC); exp_addr.push_back(32'h0020_00B0);
    exp_addr.push_back(32'h0020_014C); exp_addr.push_back(32'h0020_0150);
    run_cmd(6'd3, 5'd1, 6'd2, 5'd2, 4'd5, 1, 14, 4, 0, 1'b1);

    // Clipped at the bottom-right corner
    exp_addr.delete();
    exp_addr.push_back(32'h0020_12B8); exp_addr.push_back(32'h0020_12BC);
    run_cmd(6'd38, 5'd29, 6'd5, 5'd3, 4'd9, 1, 8, 2, 0, 1'b0);

    // Empty commands; ready held high outside writes must be ignored
    exp_addr.delete();
    ready_idle = 1'b1;
    run_cmd(6'd4, 5'd4, 6'd0, 5'd3, 4'd1, 1, 2, 0, 0, 1'b0);
    run_cmd(6'd40, 5'd2, 6'd3, 5'd3, 4'd2, 1, 2, 0, 0, 1'b0);
    run_cmd(6'd0, 5'd30, 6'd3, 5'd3, 4'd2, 1, 2, 0, 0, 1'b0);
    ready_idle = 1'b0;

    // Slow responder: 4 stable valid cycles per write
    exp_addr.delete();
    exp_addr.push_back(32'h0020_0000); exp_addr.push_back(32'h0020_0004);
    run_cmd(6'd0, 5'd0, 6'd2, 5'd1, 4'hA, 3, 12, 2, 0, 1'b0);

    // Reset during the second write of a 4x4 fill
    exp_addr.delete();
    exp_addr.push_back(32'h0020_0000); exp_addr.push_back(32'h0020_0004);
    run_cmd(6'd0, 5'd0, 6'd4, 5'd4, 4'd7, 1, 0, 0, 5, 1'b0);
    check("second_write_valid", 32'(iomem_valid), 32'd1);
    resetn = 1'b0;
    iomem_ready = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(iomem_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    exp_addr.delete();
    exp_addr.push_back(32'h0020_12BC);
    run_cmd(6'd39, 5'd29, 6'd1, 5'd1, 4'hF, 1, 5, 1, 0, 1'b0);

`ifdef VGA_BLIT_TIMEOUT_EN
    // Ready never arrives: valid for TIMEOUT cycles, then err and done
    exp_addr.delete();
    exp_addr.push_back(32'h0020_0000);
    run_cmd(6'd0, 5'd0, 6'd1, 5'd1, 4'd3, 1000, 10, 0, 0, 1'b0);
    check("timeout_err", 32'(err), 32'd1);
    exp_addr.delete();
    exp_addr.push_back(32'h0020_0008);
    run_cmd(6'd2, 5'd0, 6'd1, 5'd1, 4'd6, 1, 5, 1, 0, 1'b0);
`endif
    check("err_final", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
